// File: rtl/loader_pkg.sv
// Shared types for the program loader: top-level FSM states and error codes.
package loader_pkg;

    typedef enum logic [2:0] {
        HDR,
        LOAD,
        REL,
        STHI,
        STLO,
        RUN,
        ERR
    } state_t;

    localparam logic [1:0] ERR_NONE    = 2'd0;
    localparam logic [1:0] ERR_LEN     = 2'd1;
    localparam logic [1:0] ERR_TIMEOUT = 2'd2;
    localparam logic [1:0] ERR_CSUM    = 2'd3;

endpackage

// File: rtl/loader_start_seq.sv
// Start/timeout timer for the CPU start handshake: measures the cpu_start high
// phase and the wait for cpu_done to fall after start is released.
module loader_start_seq #(
    parameter int START_CYCLES = 2,
    parameter int TIMEOUT      = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic i_hi,
    input  logic i_lo,
    input  logic i_cpu_done,
    output logic o_go,
    output logic o_ok,
    output logic o_timeout
);

    localparam int MAX_CYC = (START_CYCLES > TIMEOUT) ? START_CYCLES : TIMEOUT;
    localparam int CW      = $clog2(MAX_CYC + 1);

    localparam logic [CW-1:0] HI_LAST = CW'(START_CYCLES - 1);
    localparam logic [CW-1:0] LO_LAST = CW'(TIMEOUT - 1);
    localparam logic [CW-1:0] ONE     = CW'(1);

    logic [CW-1:0] r_cnt;

    // o_go ends the high phase; ok/timeout resolve the low phase on the same edge.
    assign o_go      = i_hi && (r_cnt == HI_LAST);
    assign o_ok      = i_lo && !i_cpu_done;
    assign o_timeout = i_lo && i_cpu_done && (r_cnt == LO_LAST);

    // NOTE: sequential state uses non-blocking assignments only, so every
    // register in the block samples the same pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt <= '0;
        end else if (!(i_hi || i_lo) || o_go || o_ok || o_timeout) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= r_cnt + ONE;
        end
    end

endmodule

// File: rtl/program_loader.sv
// Loads a length-prefixed byte stream into CPU memory, then releases and starts
// the CPU. Optional trailing checksum byte enabled by LOADER_CHECKSUM_EN.
module program_loader
    import loader_pkg::*;
#(
    parameter int ADDR_W       = 5,
    parameter int DATA_W       = 8,
    parameter int START_CYCLES = 2,
    parameter int TIMEOUT      = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              s_valid,
    output logic              s_ready,
    input  logic [DATA_W-1:0] s_data,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic              cpu_rst,
    output logic              cpu_start,
    input  logic              cpu_done,
    output logic              busy,
    output logic              loaded,
    output logic              err,
    output logic [1:0]        err_code
);

    localparam int unsigned     CAP     = 1 << ADDR_W;
    localparam logic [ADDR_W:0] CNT_ONE = (ADDR_W + 1)'(1);

    state_t              r_state;
    logic [ADDR_W:0]     r_cnt;
    logic [ADDR_W:0]     r_len;
    logic                r_mem_we;
    logic [ADDR_W-1:0]   r_mem_addr;
    logic [DATA_W-1:0]   r_mem_wdata;
    logic                r_cpu_rst;
    logic                r_cpu_start;
    logic                r_busy;
    logic                r_loaded;
    logic                r_err;
    logic [1:0]          r_err_code;
`ifdef LOADER_CHECKSUM_EN
    logic [DATA_W-1:0]   r_csum;
`endif

    logic                w_accept;
    logic                w_len_ok;
    logic                w_hi_end;
    logic                w_ok;
    logic                w_timeout;
    logic [ADDR_W:0]     w_cnt_nxt;

    assign s_ready   = (r_state inside {HDR, LOAD, RUN, ERR});
    assign w_accept  = s_valid && s_ready;
    assign w_len_ok  = (s_data != '0) && (32'(s_data) <= CAP);
    assign w_cnt_nxt = r_cnt + CNT_ONE;

    assign mem_we    = r_mem_we;
    assign mem_addr  = r_mem_addr;
    assign mem_wdata = r_mem_wdata;
    assign cpu_rst   = r_cpu_rst;
    assign cpu_start = r_cpu_start;
    assign busy      = r_busy;
    assign loaded    = r_loaded;
    assign err       = r_err;
    assign err_code  = r_err_code;

    loader_start_seq #(
        .START_CYCLES (START_CYCLES),
        .TIMEOUT      (TIMEOUT)
    ) u_start_seq (
        .clk        (clk),
        .rst        (rst),
        .i_hi       (r_state == STHI),
        .i_lo       (r_state == STLO),
        .i_cpu_done (cpu_done),
        .o_go       (w_hi_end),
        .o_ok       (w_ok),
        .o_timeout  (w_timeout)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= HDR;
            r_cnt       <= '0;
            r_len       <= '0;
            r_mem_we    <= 1'b0;
            r_mem_addr  <= '0;
            r_mem_wdata <= '0;
            r_cpu_rst   <= 1'b1;
            r_cpu_start <= 1'b0;
            r_busy      <= 1'b0;
            r_loaded    <= 1'b0;
            r_err       <= 1'b0;
            r_err_code  <= ERR_NONE;
`ifdef LOADER_CHECKSUM_EN
            r_csum      <= '0;
`endif
        end else begin
            r_mem_we <= 1'b0;
            case (r_state)
                // Every accepted byte in these states is a header.
                HDR, RUN, ERR: begin
                    if (w_accept) begin
                        r_cpu_rst <= 1'b1;
                        r_loaded  <= 1'b0;
                        if (w_len_ok) begin
                            r_len      <= s_data[ADDR_W:0];
                            r_cnt      <= '0;
                            r_busy     <= 1'b1;
                            r_err      <= 1'b0;
                            r_err_code <= ERR_NONE;
`ifdef LOADER_CHECKSUM_EN
                            r_csum     <= '0;
`endif
                            r_state    <= LOAD;
                        end else begin
                            r_busy     <= 1'b0;
                            r_err      <= 1'b1;
                            r_err_code <= ERR_LEN;
                            r_state    <= ERR;
                        end
                    end
                end
                LOAD: begin
                    if (w_accept) begin
`ifdef LOADER_CHECKSUM_EN
                        if (r_cnt == r_len) begin
                            if (s_data == r_csum) begin
                                r_state <= REL;
                            end else begin
                                r_busy     <= 1'b0;
                                r_err      <= 1'b1;
                                r_err_code <= ERR_CSUM;
                                r_state    <= ERR;
                            end
                        end else begin
                            r_mem_we    <= 1'b1;
                            r_mem_addr  <= r_cnt[ADDR_W-1:0];
                            r_mem_wdata <= s_data;
                            r_csum      <= r_csum + s_data;
                            r_cnt       <= w_cnt_nxt;
                        end
`else
                        r_mem_we    <= 1'b1;
                        r_mem_addr  <= r_cnt[ADDR_W-1:0];
                        r_mem_wdata <= s_data;
                        r_cnt       <= w_cnt_nxt;
                        if (w_cnt_nxt == r_len) begin
                            r_state <= REL;
                        end
`endif
                    end
                end
                // Start is only raised once the CPU has seen a full cycle out of reset.
                REL: begin
                    r_cpu_rst <= 1'b0;
                    if (!r_cpu_rst && cpu_done) begin
                        r_cpu_start <= 1'b1;
                        r_state     <= STHI;
                    end
                end
                STHI: begin
                    if (w_hi_end) begin
                        r_cpu_start <= 1'b0;
                        r_state     <= STLO;
                    end
                end
                STLO: begin
                    if (w_ok) begin
                        r_busy   <= 1'b0;
                        r_loaded <= 1'b1;
                        r_state  <= RUN;
                    end else if (w_timeout) begin
                        r_busy     <= 1'b0;
                        r_err      <= 1'b1;
                        r_err_code <= ERR_TIMEOUT;
                        r_cpu_rst  <= 1'b1;
                        r_state    <= ERR;
                    end
                end
                default: r_state <= HDR;
            endcase
        end
    end

endmodule

// File: tb/tb_program_loader.sv
// Randomized scoreboard bench for program_loader; honours LOADER_CHECKSUM_EN.
module tb_program_loader;

    localparam int ADDR_W       = 5;
    localparam int DATA_W       = 8;
    localparam int START_CYCLES = 2;
    localparam int TIMEOUT      = 16;
    localparam int CAP          = 1 << ADDR_W;
`ifdef LOADER_CHECKSUM_EN
    localparam bit CSUM_EN = 1'b1;
`else
    localparam bit CSUM_EN = 1'b0;
`endif

    typedef struct packed {
        logic [ADDR_W-1:0] a;
        logic [DATA_W-1:0] d;
    } wr_t;

    typedef enum int {OUT_OK = 0, OUT_LEN = 1, OUT_TO = 2, OUT_CSUM = 3} outcome_e;

    logic              clk = 1'b0;
    logic              rst;
    logic              s_valid;
    logic              s_ready;
    logic [DATA_W-1:0] s_data;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic              cpu_rst;
    logic              cpu_start;
    logic              cpu_done;
    logic              busy;
    logic              loaded;
    logic              err;
    logic [1:0]        err_code;

    int  n_vec  = 0;
    int  n_fail = 0;
    int  cyc    = 0;
    int  t_last_wr    = -1;
    int  t_start_fall = 0;
    int  t_err_rise   = 0;
    bit  cpu_hang     = 1'b0;

    wr_t             exp_wr[$];
    int              exp_start[$];
    int              wr_cyc[$];
    logic [DATA_W-1:0] prog[CAP];

    program_loader #(
        .ADDR_W       (ADDR_W),
        .DATA_W       (DATA_W),
        .START_CYCLES (START_CYCLES),
        .TIMEOUT      (TIMEOUT)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .s_valid   (s_valid),
        .s_ready   (s_ready),
        .s_data    (s_data),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .cpu_rst   (cpu_rst),
        .cpu_start (cpu_start),
        .cpu_done  (cpu_done),
        .busy      (busy),
        .loaded    (loaded),
        .err       (err),
        .err_code  (err_code)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Behavioural CPU: done=1 while idle/in reset, leaves IDLE one cycle after start falls.
    initial begin : cpu_model
        bit armed;
        bit prev_start;
        armed      = 1'b0;
        prev_start = 1'b0;
        cpu_done   = 1'b1;
        forever begin
            @(negedge clk);
            if (rst || cpu_rst) begin
                cpu_done = 1'b1;
                armed    = 1'b0;
            end else if (armed && !cpu_hang) begin
                cpu_done = 1'b0;
            end else if (prev_start && !cpu_start) begin
                armed = 1'b1;
            end
            prev_start = cpu_start;
        end
    end

    // Monitor: pops expected writes / start pulses as the DUT presents them.
    initial begin : monitor
        wr_t e;
        int  hi;
        bit  prev_rst;
        bit  prev_err;
        hi       = 0;
        prev_rst = 1'b1;
        prev_err = 1'b0;
        forever begin
            @(negedge clk);
            cyc++;
            if (!rst) begin
                if (mem_we) begin
                    check("wr_expected", 32'(exp_wr.size() != 0), 1);
                    if (exp_wr.size() != 0) begin
                        e = exp_wr.pop_front();
                        check("wr_addr", 32'(mem_addr), 32'(e.a));
                        check("wr_data", 32'(mem_wdata), 32'(e.d));
                    end
                    wr_cyc.push_back(cyc);
                    t_last_wr = cyc;
                end
                if (prev_rst && !cpu_rst) begin
                    check("release_pending_writes", exp_wr.size(), 0);
                    check("release_after_last_write", 32'(cyc > t_last_wr), 1);
                end
                if (cpu_start) begin
                    hi++;
                end else if (hi != 0) begin
                    check("start_expected", 32'(exp_start.size() != 0), 1);
                    if (exp_start.size() != 0) check("start_cycles", hi, exp_start.pop_front());
                    hi = 0;
                    t_start_fall = cyc;
                end
                if (err && !prev_err) t_err_rise = cyc;
                prev_rst = cpu_rst;
                prev_err = err;
            end
        end
    end

    initial begin : watchdog
        #2ms;
        $display("FAIL watchdog: simulation did not finish, vectors %0d", n_vec);
        $fatal(1, "watchdog expired");
    end

    // Called at a negedge; returns at the negedge after the byte transferred.
    task automatic send_byte(input logic [DATA_W-1:0] b);
        int n = 0;
        s_valid = 1'b1;
        s_data  = b;
        while (!s_ready && n < 500) begin
            @(negedge clk);
            n++;
        end
        check("s_ready_wait", 32'(n < 500), 1);
        @(negedge clk);
        s_valid = 1'b0;
    endtask

    task automatic idle_gap(input int max_gap);
        repeat ($urandom_range(0, max_gap)) @(negedge clk);
    endtask

    task automatic wait_settle();
        int n = 0;
        while (!(loaded || err) && n < 500) begin
            @(negedge clk);
            n++;
        end
        check("settle_wait", 32'(n < 500), 1);
    endtask

    function automatic outcome_e predict(input bit valid, input bit hang, input bit csum_bad);
        if (!valid) return OUT_LEN;
        if (CSUM_EN && csum_bad) return OUT_CSUM;
        if (hang) return OUT_TO;
        return OUT_OK;
    endfunction

    task automatic run_program(input int len, input bit hang, input int csum_delta, input int max_gap);
        bit                valid;
        outcome_e          exp_o;
        logic [DATA_W-1:0] sum;
        valid    = (len >= 1) && (len <= CAP);
        sum      = '0;
        cpu_hang = hang;
        if (valid) begin
            for (int i = 0; i < len; i++) begin
                exp_wr.push_back('{a: ADDR_W'(i), d: prog[i]});
                sum = sum + prog[i];
            end
        end
        exp_o = predict(valid, hang, csum_delta != 0);
        if (exp_o == OUT_OK || exp_o == OUT_TO) exp_start.push_back(START_CYCLES);

        send_byte(DATA_W'(len));
        if (valid) begin
            check("hdr_busy", 32'(busy), 1);
            check("hdr_cpu_rst", 32'(cpu_rst), 1);
            check("hdr_loaded", 32'(loaded), 0);
            check("hdr_err", 32'(err), 0);
            for (int i = 0; i < len; i++) begin
                idle_gap(max_gap);
                send_byte(prog[i]);
            end
            if (CSUM_EN) begin
                idle_gap(max_gap);
                send_byte(sum + DATA_W'(csum_delta));
            end
        end
        wait_settle();
        check("st_loaded", 32'(loaded), 32'(exp_o == OUT_OK));
        check("st_busy", 32'(busy), 0);
        check("st_err", 32'(err), 32'(exp_o != OUT_OK));
        check("st_err_code", 32'(err_code), 32'(int'(exp_o)));
        check("st_cpu_rst", 32'(cpu_rst), 32'(exp_o != OUT_OK));
        if (exp_o == OUT_TO) check("timeout_cycles", t_err_rise - t_start_fall, TIMEOUT);
        cpu_hang = 1'b0;
    endtask

    initial begin : stimulus
        int r;
        int len;
        bit hang;
        int dlt;
        rst     = 1'b1;
        s_valid = 1'b0;
        s_data  = '0;
        repeat (3) @(negedge clk);
        check("rst_cpu_rst", 32'(cpu_rst), 1);
        check("rst_cpu_start", 32'(cpu_start), 0);
        check("rst_mem_we", 32'(mem_we), 0);
        check("rst_mem_addr", 32'(mem_addr), 0);
        check("rst_mem_wdata", 32'(mem_wdata), 0);
        check("rst_busy", 32'(busy), 0);
        check("rst_loaded", 32'(loaded), 0);
        check("rst_err", 32'(err), 0);
        check("rst_err_code", 32'(err_code), 0);
        rst = 1'b0;
        @(negedge clk);
        check("rst_s_ready", 32'(s_ready), 1);

        // Back-to-back three-byte program.
        prog[0] = 8'h21;
        prog[1] = 8'h42;
        prog[2] = 8'h63;
        wr_cyc.delete();
        run_program(3, 1'b0, 0, 0);
        check("b2b_writes", wr_cyc.size(), 3);
        if (wr_cyc.size() == 3) check("b2b_span", wr_cyc[2] - wr_cyc[0], 2);

        // Bad lengths: zero and one past capacity.
        run_program(0, 1'b0, 0, 0);
        run_program(CAP + 1, 1'b0, 0, 0);

        // Full memory.
        for (int i = 0; i < CAP; i++) prog[i] = 8'($urandom);
        run_program(CAP, 1'b0, 0, 2);

        // CPU never leaves IDLE, then a valid program recovers.
        for (int i = 0; i < 5; i++) prog[i] = 8'($urandom);
        run_program(5, 1'b1, 0, 1);
        for (int i = 0; i < 4; i++) prog[i] = 8'($urandom);
        run_program(4, 1'b0, 0, 1);

        // Reload while running.
        prog[0] = 8'hA5;
        prog[1] = 8'h5A;
        run_program(2, 1'b0, 0, 0);

`ifdef LOADER_CHECKSUM_EN
        prog[0] = 8'h10;
        prog[1] = 8'h20;
        run_program(2, 1'b0, 1, 0);
        run_program(2, 1'b0, 0, 0);
`endif

        for (int it = 0; it < 24; it++) begin
            r    = $urandom_range(0, 9);
            len  = $urandom_range(1, CAP);
            hang = 1'b0;
            dlt  = 0;
            if (r == 0) len = $urandom_range(0, 1) ? 0 : $urandom_range(CAP + 1, 255);
            else if (r == 1) hang = 1'b1;
            else if (r == 2 && CSUM_EN) dlt = $urandom_range(1, 255);
            for (int i = 0; i < CAP; i++) prog[i] = 8'($urandom);
            run_program(len, hang, dlt, $urandom_range(0, 3));
        end

        repeat (5) @(negedge clk);
        check("leftover_writes", exp_wr.size(), 0);
        check("leftover_starts", exp_start.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule

// File: doc/program_loader.md
Name: program_loader

Overview:
- Upstream feeder of the multicycle accumulator CPU.
- Accepts a length-prefixed program byte stream from a host over a valid/ready handshake and writes the bytes into CPU memory from address 0.
- Holds the CPU in reset while loading, then releases it and drives the CPU start handshake: start high, then low, then confirm that the CPU has left IDLE (done falls).
- Reports status (busy/loaded/error) and lets the host restart with a new program at any time.

Parameters:
ADDR_W, 5, memory address width; capacity 2^ADDR_W bytes
DATA_W, 8, program byte width
START_CYCLES, 2, cycles cpu_start is held high (>=1)
TIMEOUT, 16, max cycles to wait for cpu_done to fall after start is released

Ports:
clk  in  1  clock
rst  in  1  asynchronous, active-high reset
s_valid  in  1  host byte valid
s_ready  out  1  loader can accept a byte
s_data  in  DATA_W  host byte
mem_we  out  1  memory write strobe
mem_addr  out  ADDR_W  memory write address
mem_wdata  out  DATA_W  memory write data
cpu_rst  out  1  reset to the CPU controller/datapath
cpu_start  out  1  start input of the CPU controller
cpu_done  in  1  done output of the CPU controller (1 only in its IDLE state)
busy  out  1  load or start sequence in progress
loaded  out  1  CPU confirmed running the current program
err  out  1  sticky error flag
err_code  out  2  0 none, 1 bad length, 2 start timeout, 3 checksum

Behaviour:
- Transfer: a byte transfers on a clk edge where s_valid and s_ready are both high.
- s_ready: combinational from state; 1 in HDR, LOAD, RUN and ERR; 0 otherwise.
- Reset values: state HDR, cpu_rst=1, cpu_start=0, mem_we=0, mem_addr=0, mem_wdata=0, busy=0, loaded=0, err=0, err_code=0. Counters cleared.
- Async rst mid-load or mid-start aborts immediately; partial memory contents are left as written.
- HDR:
  - Accepted byte = length L.
  - L==0 or L>2^ADDR_W -> ERR, code 1.
  - Otherwise: cnt=0, busy=1, cpu_rst=1, err cleared -> LOAD.
- LOAD:
  - Each accepted byte is registered: next cycle mem_we=1, mem_addr=cnt[ADDR_W-1:0], mem_wdata=byte, then cnt++.
  - Write latency is 1 cycle; back-to-back bytes give back-to-back writes.
  - After the L-th byte -> REL.
  - L==2^ADDR_W fills memory; cnt is ADDR_W+1 bits wide, so the address does not wrap before the end.
- REL: cpu_rst=0; wait until cpu_done==1 -> STHI.
- STHI: cpu_start=1 for exactly START_CYCLES cycles -> STLO.
- STLO:
  - cpu_start=0; timer counts.
  - cpu_done==0 -> RUN, busy=0, loaded=1.
  - Timer reaches TIMEOUT with done still 1 -> ERR, code 2, cpu_rst=1.
- RUN: CPU runs freely. An accepted byte is a new header:
  - Valid length: cpu_rst=1, loaded=0 in the same edge, then LOAD.
  - Invalid length: cpu_rst=1 -> ERR, code 1.
- ERR:
  - err=1, busy=0, cpu_rst=1.
  - The next accepted byte is treated as a header, same rules as HDR.
  - err/err_code clear only on a valid header.
- s_valid with s_ready low (REL/STHI/STLO) is ignored; the host must hold s_valid.

Optional Feature:
- Macro: LOADER_CHECKSUM_EN.
- Defined: LOAD expects L program bytes plus one trailing checksum byte, equal to the sum of the program bytes mod 2^DATA_W. The checksum byte is not written to memory. Mismatch -> ERR, code 3, no start. Match -> REL.
- Undefined: no checksum byte; code 3 never produced.

Decomposition:
- Shared package loader_pkg:
  - state enum (HDR, LOAD, REL, STHI, STLO, RUN, ERR)
  - err_code constants (ERR_NONE, ERR_LEN, ERR_TIMEOUT, ERR_CSUM)
- Sub-module: loader_start_seq, a start/timeout timer handling STHI/STLO counting, with go/ok/timeout outputs.

Test Plan:
- L=3, bytes 0x21,0x42,0x63 streamed back-to-back, cpu_done held 1 then dropped 1 cycle after cpu_start falls:
  - writes (0,0x21),(1,0x42),(2,0x63) on consecutive cycles
  - cpu_rst falls after the last write
  - cpu_start high exactly 2 cycles
  - loaded=1, busy=0
- Header 0x00, and separately header 33 with ADDR_W=5 -> err=1, err_code=1, no mem_we, cpu_rst stays 1.
- L=32 full memory -> last write at address 31, no wrap, start sequence follows.
- cpu_done held 1 forever after start -> after 16 cycles err_code=2, cpu_rst=1; a new valid header clears err.
- While in RUN, send header 2 plus two bytes -> cpu_rst rises on the header edge, loaded=0, memory rewritten at 0 and 1, CPU restarted.
- With LOADER_CHECKSUM_EN, bytes 0x10,0x20 followed by checksum 0x31 -> err_code=3, no start. Repeated with checksum 0x30 -> loaded=1, checksum never written to memory.
